// File: rtl/spi_frame_ctrl_pkg.sv
// Shared definitions for the UART-to-SPI framing controller: state encoding,
// protocol byte constants and a small saturating-decrement helper.
package spi_frame_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_R,
    ST_SETUP,
    ST_WRITE,
    ST_READ,
    ST_HOLD,
    ST_ACK,
    ST_NAK,
    ST_ABORT
  } state_t;

  localparam int         TMR_W          = 24;
  localparam logic [7:0] DUMMY_BYTE_DEF = 8'hFF;
  localparam logic [7:0] ACK_BYTE_DEF   = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF   = 8'h15;

  // Byte counters stop at zero instead of wrapping.
  function automatic logic [7:0] dec_sat(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

endpackage

// File: rtl/spi_frame_timer.sv
// Saturating cycle counter shared by the setup delay, hold delay and inter-byte
// timeout. done is suppressed during a clear so a stale count never leaks into
// the state that is just being entered.
module spi_frame_timer
  import spi_frame_ctrl_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;

  // Clear has priority; counting stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = !clr && (cnt >= limit);

endmodule

// File: rtl/spi_frame_ctrl.sv
// Framing controller between the UART byte stream and the SPI byte engine.
// Host sends WCOUNT, RCOUNT, then WCOUNT bytes; the block frames them with
// spi_ss, returns RCOUNT read bytes to the UART and closes with ACK or NAK.
module spi_frame_ctrl
  import spi_frame_ctrl_pkg::*;
#(
  parameter int         SETUP_CYCLES   = 12,
  parameter int         HOLD_CYCLES    = 12,
  parameter int         TIMEOUT_CYCLES = 12000000,
  parameter logic [7:0] DUMMY_BYTE     = DUMMY_BYTE_DEF,
  parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE       = NAK_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_valid,
  input  logic [7:0] uart_rx_data,
  output logic       uart_rx_ready,
  input  logic       uart_rx_break,
  output logic       uart_tx_valid,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_ready,
  output logic       spi_tx_valid,
  output logic [7:0] spi_tx_data,
  input  logic       spi_tx_ready,
  input  logic       spi_rx_valid,
  input  logic [7:0] spi_rx_data,
  output logic       spi_rx_ready,
  output logic       spi_ss,
  output logic       busy
);

  state_t             state;
  state_t             state_prev;
  logic [7:0]         wcnt;
  logic [7:0]         rcnt;
  logic               pending;
  logic               armed;
  logic [7:0]         rd_data;
  logic               tmr_clr;
  logic               tmr_en;
  logic               tmr_done;
  logic [TMR_W-1:0]   tmr_limit;
  logic               uart_rx_xfer;
  logic               uart_tx_xfer;
  logic               spi_tx_xfer;
  logic               spi_rx_xfer;

  assign uart_rx_xfer = uart_rx_valid & uart_rx_ready;
  assign uart_tx_xfer = uart_tx_valid & uart_tx_ready;
  assign spi_tx_xfer  = spi_tx_valid & spi_tx_ready;
  assign spi_rx_xfer  = spi_rx_valid & spi_rx_ready;

  // Handshake steering; WRITE passes UART bytes straight to SPI with no latency.
  always_comb begin
    uart_rx_ready = 1'b0;
    spi_tx_valid  = 1'b0;
    spi_tx_data   = DUMMY_BYTE;
    spi_rx_ready  = 1'b0;
    uart_tx_data  = rd_data;
    case (state)
      ST_IDLE, ST_GET_R: uart_rx_ready = armed;
      ST_WRITE: begin
        spi_tx_valid  = uart_rx_valid & ~pending & (wcnt != 8'd0);
        spi_tx_data   = uart_rx_data;
        uart_rx_ready = spi_tx_ready & ~pending & (wcnt != 8'd0);
        spi_rx_ready  = 1'b1;
      end
      ST_READ: begin
        spi_tx_valid = ~pending & (rcnt != 8'd0);
        spi_rx_ready = ~uart_tx_valid;
      end
      ST_ABORT: spi_rx_ready = 1'b1;
      ST_ACK:   uart_tx_data = ACK_BYTE;
      ST_NAK:   uart_tx_data = NAK_BYTE;
      default: ;
    endcase
  end

  // Timer restarts on every state entry and every accepted host byte; the gap
  // timeout only runs while actually waiting for the host.
  always_comb begin
    tmr_clr = (state != state_prev) | uart_rx_xfer;
    tmr_en  = (state == ST_SETUP) || (state == ST_HOLD) ||
              (((state == ST_GET_R) || ((state == ST_WRITE) && (wcnt != 8'd0))) && !uart_rx_valid);
    case (state)
      ST_SETUP: tmr_limit = TMR_W'(SETUP_CYCLES);
      ST_HOLD:  tmr_limit = TMR_W'(HOLD_CYCLES);
      default:  tmr_limit = TMR_W'(TIMEOUT_CYCLES);
    endcase
  end

  spi_frame_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  // Read bytes from the SPI engine, held for the UART transmitter.
  always_ff @(posedge clk) begin
    if ((state == ST_READ) && spi_rx_xfer) begin
      rd_data <= spi_rx_data;
    end
  end

  // Frame sequencer with registered chip select, busy and UART tx valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      state_prev    <= ST_IDLE;
      wcnt          <= 8'd0;
      rcnt          <= 8'd0;
      pending       <= 1'b0;
      armed         <= 1'b0;
      spi_ss        <= 1'b1;
      busy          <= 1'b0;
      uart_tx_valid <= 1'b0;
    end else begin
      state_prev <= state;
      armed      <= 1'b1;
      if (spi_tx_xfer) begin
        pending <= 1'b1;
      end else if (spi_rx_xfer) begin
        pending <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (uart_rx_xfer) begin
            wcnt  <= uart_rx_data;
            state <= ST_GET_R;
          end
        end
        ST_GET_R: begin
          if (uart_rx_xfer) begin
            rcnt <= uart_rx_data;
          end
          if (uart_rx_break || tmr_done) begin
            state <= ST_ABORT;
          end else if (uart_rx_xfer) begin
            if ((wcnt == 8'd0) && (uart_rx_data == 8'd0)) begin
              uart_tx_valid <= 1'b1;
              state         <= ST_ACK;
            end else begin
              spi_ss <= 1'b0;
              busy   <= 1'b1;
              state  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (uart_rx_break) begin
            state <= ST_ABORT;
          end else if (tmr_done) begin
            state <= (wcnt != 8'd0) ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (spi_tx_xfer) begin
            wcnt <= dec_sat(wcnt);
          end
          if (uart_rx_break || tmr_done) begin
            state <= ST_ABORT;
          end else if ((wcnt == 8'd0) && !pending) begin
            state <= (rcnt != 8'd0) ? ST_READ : ST_HOLD;
          end
        end
        ST_READ: begin
          if (spi_tx_xfer) begin
            rcnt <= dec_sat(rcnt);
          end
          if (uart_rx_break) begin
            uart_tx_valid <= 1'b0;
            state         <= ST_ABORT;
          end else begin
            if (spi_rx_xfer) begin
              uart_tx_valid <= 1'b1;
            end else if (uart_tx_xfer) begin
              uart_tx_valid <= 1'b0;
            end
            if ((rcnt == 8'd0) && !pending && !uart_tx_valid) begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (uart_rx_break) begin
            state <= ST_ABORT;
          end else if (tmr_done) begin
            spi_ss        <= 1'b1;
            uart_tx_valid <= 1'b1;
            state         <= ST_ACK;
          end
        end
        ST_ACK, ST_NAK: begin
          if (uart_tx_xfer) begin
            uart_tx_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        ST_ABORT: begin
          if (!pending) begin
            spi_ss        <= 1'b1;
            uart_tx_valid <= 1'b1;
            state         <= ST_NAK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: directed host frames, a behavioural SPI engine and
// a queue scoreboard checking every byte leaving the block on SPI and UART.
module tb_spi_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_ready;
  logic       uart_rx_break;
  logic       uart_tx_valid;
  logic [7:0] uart_tx_data;
  logic       uart_tx_ready;
  logic       spi_tx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_ready;
  logic       spi_rx_valid;
  logic [7:0] spi_rx_data;
  logic       spi_rx_ready;
  logic       spi_ss;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_spi[$];
  logic [7:0] exp_uart[$];
  logic [7:0] resp_q[$];

  int spi_lat    = 3;
  int rst_epoch  = 0;
  bit model_busy = 0;
  bit hold_chk   = 0;
  bit ss_ever_low = 0;
  int ss_low_cnt = 0;
  int since_rx   = 0;
  logic ss_prev  = 1'b1;

  always #5 clk = ~clk;

  spi_frame_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_ready (uart_rx_ready),
    .uart_rx_break (uart_rx_break),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .spi_tx_valid  (spi_tx_valid),
    .spi_tx_data   (spi_tx_data),
    .spi_tx_ready  (spi_tx_ready),
    .spi_rx_valid  (spi_rx_valid),
    .spi_rx_data   (spi_rx_data),
    .spi_rx_ready  (spi_rx_ready),
    .spi_ss        (spi_ss),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  always @(negedge rst_n) rst_epoch++;

  // Scoreboard monitor: every output transfer is sampled mid-cycle and popped.
  always @(negedge clk) begin
    ss_low_cnt = spi_ss ? 0 : ss_low_cnt + 1;
    if (!spi_ss) ss_ever_low = 1;
    if (rst_n) begin
      if (spi_tx_valid && spi_tx_ready) begin
        if (exp_spi.size() == 0) fail("spi_tx_unexpected", {24'd0, spi_tx_data});
        else check("spi_tx_data", {24'd0, spi_tx_data}, {24'd0, exp_spi.pop_front()});
        check("ss_setup_before_spi", {31'd0, (ss_low_cnt >= 12)}, 32'd1);
      end
      if (uart_tx_valid && uart_tx_ready) begin
        if (exp_uart.size() == 0) fail("uart_tx_unexpected", {24'd0, uart_tx_data});
        else check("uart_tx_data", {24'd0, uart_tx_data}, {24'd0, exp_uart.pop_front()});
      end
      if (hold_chk && spi_ss && !ss_prev)
        check("ss_hold_after_rx", {31'd0, (since_rx >= 12)}, 32'd1);
    end
    since_rx = (spi_rx_valid && spi_rx_ready) ? 0 : since_rx + 1;
    ss_prev  = spi_ss;
  end

  // Behavioural SPI engine: one rx byte per tx byte after spi_lat cycles.
  initial begin : spi_model
    int ep;
    int n;
    logic [7:0] r;
    spi_rx_valid = 1'b0;
    spi_rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && spi_tx_valid && spi_tx_ready) begin
        ep = rst_epoch;
        r = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
        model_busy = 1;
        repeat (spi_lat) @(posedge clk);
        #1;
        if (ep == rst_epoch) begin
          spi_rx_valid = 1'b1;
          spi_rx_data  = r;
          n = 0;
          forever begin
            @(negedge clk);
            if (ep != rst_epoch || spi_rx_ready) break;
            n++;
            if (n > 500) begin
              fail("spi_rx_never_accepted", {24'd0, r});
              break;
            end
          end
          @(posedge clk);
          #1;
          spi_rx_valid = 1'b0;
        end
        model_busy = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge clk);
    #1;
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (uart_rx_ready) break;
      n++;
      if (n > 2000) begin
        fail("uart_rx_stuck", {24'd0, b});
        break;
      end
    end
    @(posedge clk);
    #1;
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_uart.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_uart.size() != 0) fail({name, "_uart_timeout"}, exp_uart.size());
    repeat (2) @(negedge clk);
    check({name, "_spi_left"}, exp_spi.size(), 32'd0);
    check({name, "_ss_idle"}, {31'd0, spi_ss}, 32'd1);
    check({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check({name, "_spi_drained"}, {31'd0, model_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_break = 1'b0;
    uart_tx_ready = 1'b1;
    spi_tx_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss", {31'd0, spi_ss}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_uart_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
    check("rst_uart_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
    check("rst_spi_tx_valid", {31'd0, spi_tx_valid}, 32'd0);
    check("rst_spi_rx_ready", {31'd0, spi_rx_ready}, 32'd0);
    rst_n = 1'b1;

    // Write-only frame: 02 00 9F 00
    hold_chk = 1;
    exp_spi.push_back(8'h9F); exp_spi.push_back(8'h00);
    exp_uart.push_back(8'h06);
    send_byte(8'h02);
    send_byte(8'h00);
    check("f1_busy_set", {31'd0, busy}, 32'd1);
    check("f1_ss_low", {31'd0, spi_ss}, 32'd0);
    send_byte(8'h9F);
    send_byte(8'h00);
    wait_done("f1");

    // Write then read: 01 03 9F, engine returns xx EF 40 18
    resp_q.push_back(8'h00); resp_q.push_back(8'hEF);
    resp_q.push_back(8'h40); resp_q.push_back(8'h18);
    exp_spi.push_back(8'h9F); exp_spi.push_back(8'hFF);
    exp_spi.push_back(8'hFF); exp_spi.push_back(8'hFF);
    exp_uart.push_back(8'hEF); exp_uart.push_back(8'h40);
    exp_uart.push_back(8'h18); exp_uart.push_back(8'h06);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h9F);
    wait_done("f2");

    // Empty frame: 00 00, chip select never asserted
    hold_chk = 0;
    ss_ever_low = 0;
    exp_uart.push_back(8'h06);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_done("f3");
    check("f3_ss_never_low", {31'd0, ss_ever_low}, 32'd0);

    // Timeout mid-write: 04 00 AA BB then silence
    exp_spi.push_back(8'hAA); exp_spi.push_back(8'hBB);
    exp_uart.push_back(8'h15);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    wait_done("f4");

    // Break during READ with one byte in flight
    spi_lat = 30;
    resp_q.push_back(8'h99);
    exp_spi.push_back(8'hFF);
    exp_uart.push_back(8'h15);
    send_byte(8'h00);
    send_byte(8'h02);
    begin
      int n;
      n = 0;
      while (!(spi_tx_valid && spi_tx_ready) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) fail("f5_no_read_tx", n);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("f5_pending_before_break", {31'd0, model_busy}, 32'd1);
    uart_rx_break = 1'b1;
    @(posedge clk); #1;
    uart_rx_break = 1'b0;
    wait_done("f5");
    spi_lat = 3;

    // Reset mid-write, then a clean frame
    exp_spi.push_back(8'hAA);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'hAA);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ss", {31'd0, spi_ss}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_spi_tx_valid", {31'd0, spi_tx_valid}, 32'd0);
    check("mid_rst_uart_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    hold_chk = 1;
    exp_spi.push_back(8'hC3);
    exp_uart.push_back(8'h06);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hC3);
    wait_done("f7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
